// File: rtl/kcpsmx3_inc.sv
// Shared KCPSMX definitions: register-file geometry and the operand-fetch types.
package kcpsmx3_inc;

  localparam int REGISTER_DEPTH = 4;
  localparam int REGISTER_WIDTH = 8;
  localparam int REGISTER_SIZE  = 16;
  localparam int PEND_W         = 2;

  typedef logic [REGISTER_DEPTH-1:0] reg_addr_t;
  typedef logic [REGISTER_WIDTH-1:0] reg_data_t;
  typedef logic [PEND_W-1:0]         pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = '1;

  // One resolved operand: whether it blocks issue and the value to use if not.
  typedef struct packed {
    logic      stall;
    reg_data_t value;
  } operand_t;

  // Hazard resolution for one operand register, in priority order:
  // writer just ahead in the output stage, EX forward, scoreboard, register file.
  function automatic operand_t resolve_operand(
    input logic      used,
    input reg_addr_t addr,
    input reg_data_t rf_data,
    input logic      ahead_hit,
    input logic      fwd_valid,
    input reg_addr_t fwd_addr,
    input reg_data_t fwd_data,
    input logic      busy
  );
    operand_t op;
    logic     fwd_hit;
    fwd_hit  = fwd_valid && (fwd_addr == addr);
    op.value = fwd_hit ? fwd_data : rf_data;
    op.stall = used && (ahead_hit || (!fwd_hit && busy));
    return op;
  endfunction

endpackage

// File: rtl/kcpsmx_scoreboard.sv
// Per-register in-flight write counters with saturating increment, up to two
// releases per cycle (writeback and kill), and a sticky underflow flag.
module kcpsmx_scoreboard
  import kcpsmx3_inc::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc_valid,
  input  logic [REGISTER_DEPTH-1:0] inc_addr,
  input  logic                     wb_valid,
  input  logic [REGISTER_DEPTH-1:0] wb_addr,
  input  logic                     kill_valid,
  input  logic [REGISTER_DEPTH-1:0] kill_addr,
  output logic [REGISTER_SIZE-1:0]  busy,
  output logic [REGISTER_SIZE-1:0]  full,
  output logic                     underflow
);

  pend_cnt_t                pend     [REGISTER_SIZE];
  pend_cnt_t                pend_nxt [REGISTER_SIZE];
  logic [REGISTER_SIZE-1:0] uf_hit;

  // Next count per register: add the new writer, subtract releases, clamp to [0, max].
  always_comb begin
    int up;
    int down;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    up     = 0;
    down   = 0;
    uf_hit = '0;
    for (int r = 0; r < REGISTER_SIZE; r++) begin
      up   = int'(pend[r]) + ((inc_valid && inc_addr == reg_addr_t'(r)) ? 1 : 0);
      down = ((wb_valid && wb_addr == reg_addr_t'(r)) ? 1 : 0)
           + ((kill_valid && kill_addr == reg_addr_t'(r)) ? 1 : 0);
      if (up < down) begin
        uf_hit[r]   = 1'b1;
        pend_nxt[r] = '0;
      end else if (up - down > int'(PEND_MAX)) begin
        pend_nxt[r] = PEND_MAX;
      end else begin
        pend_nxt[r] = pend_cnt_t'(up - down);
      end
    end
  end

  // Counter array and sticky underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counters are a small flop array, not RAM, so they are reset
      // explicitly; a reset mid-stall must leave no stale in-flight counts.
      for (int r = 0; r < REGISTER_SIZE; r++) pend[r] <= '0;
      underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
      for (int r = 0; r < REGISTER_SIZE; r++) pend[r] <= pend_nxt[r];
      if (|uf_hit) underflow <= 1'b1;
    end
  end

  // Status vectors for the hazard logic.
  always_comb begin
    for (int r = 0; r < REGISTER_SIZE; r++) begin
      busy[r] = (pend[r] != '0);
      full[r] = (pend[r] == PEND_MAX);
    end
  end

endmodule

// File: rtl/kcpsmx_operand_fetch.sv
// Operand-fetch stage: register-file read, EX forwarding, RAW hazard stall,
// and a valid/ready output register feeding execute.
module kcpsmx_operand_fetch
  import kcpsmx3_inc::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REGISTER_DEPTH-1:0] id_x_addr,
  input  logic [REGISTER_DEPTH-1:0] id_y_addr,
  input  logic                      id_use_x,
  input  logic                      id_use_y,
  input  logic [REGISTER_WIDTH-1:0] id_kk,
  input  logic                      id_wen,
  output logic [REGISTER_DEPTH-1:0] rf_x_address,
  output logic [REGISTER_DEPTH-1:0] rf_y_address,
  input  logic [REGISTER_WIDTH-1:0] rf_x_data,
  input  logic [REGISTER_WIDTH-1:0] rf_y_data,
  input  logic                      ex_fwd_valid,
  input  logic [REGISTER_DEPTH-1:0] ex_fwd_addr,
  input  logic [REGISTER_WIDTH-1:0] ex_fwd_data,
  input  logic                      wb_valid,
  input  logic [REGISTER_DEPTH-1:0] wb_addr,
  input  logic                      kill,
  output logic                      of_valid,
  input  logic                      of_ready,
  output logic [REGISTER_WIDTH-1:0] of_opa,
  output logic [REGISTER_WIDTH-1:0] of_opb,
  output logic [REGISTER_DEPTH-1:0] of_dest,
  output logic                      of_wen,
  output logic                      sb_underflow
);

  logic [REGISTER_SIZE-1:0] busy;
  logic [REGISTER_SIZE-1:0] full;
  operand_t                 op_x;
  operand_t                 op_y;
  logic                     stall;
  logic                     accept;

  assign rf_x_address = id_x_addr;
  assign rf_y_address = id_y_addr;

  // Operand resolution, stall and handshake.
  always_comb begin
    op_x = resolve_operand(id_use_x, id_x_addr, rf_x_data,
                           of_valid && of_wen && (of_dest == id_x_addr),
                           ex_fwd_valid, ex_fwd_addr, ex_fwd_data, busy[id_x_addr]);
    op_y = resolve_operand(id_use_y, id_y_addr, rf_y_data,
                           of_valid && of_wen && (of_dest == id_y_addr),
                           ex_fwd_valid, ex_fwd_addr, ex_fwd_data, busy[id_y_addr]);
    // A writer whose destination counter is saturated must wait for a release.
    stall    = op_x.stall || op_y.stall || (id_wen && full[id_x_addr]);
    id_ready = !stall && !kill && (!of_valid || of_ready);
    accept   = id_valid && id_ready;
  end

  // Output stage: load on accept, drain on consume or kill, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      of_valid <= 1'b0;
      of_opa   <= '0;
      of_opb   <= '0;
      of_dest  <= '0;
      of_wen   <= 1'b0;
    end else if (accept) begin
      of_valid <= 1'b1;
      of_opa   <= op_x.value;
      of_opb   <= id_use_y ? op_y.value : id_kk;
      of_dest  <= id_x_addr;
      of_wen   <= id_wen;
    end else if (of_ready || kill) begin
      of_valid <= 1'b0;
    end
  end

  kcpsmx_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .inc_valid  (accept && id_wen),
    .inc_addr   (id_x_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .kill_valid (kill && of_valid && of_wen),
    .kill_addr  (of_dest),
    .busy       (busy),
    .full       (full),
    .underflow  (sb_underflow)
  );

endmodule

// File: tb/tb_kcpsmx_operand_fetch.sv
// Self-checking bench for kcpsmx_operand_fetch: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_kcpsmx_operand_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_ready, id_use_x, id_use_y, id_wen;
  logic [3:0] id_x_addr, id_y_addr, rf_x_address, rf_y_address, ex_fwd_addr, wb_addr, of_dest;
  logic [7:0] id_kk, rf_x_data, rf_y_data, ex_fwd_data, of_opa, of_opb;
  logic       ex_fwd_valid, wb_valid, kill, of_valid, of_ready, of_wen, sb_underflow;

  logic [7:0] rf_mem [16];
  assign rf_x_data = rf_mem[rf_x_address];
  assign rf_y_data = rf_mem[rf_y_address];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kcpsmx_operand_fetch dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_x_addr(id_x_addr), .id_y_addr(id_y_addr),
    .id_use_x(id_use_x), .id_use_y(id_use_y), .id_kk(id_kk), .id_wen(id_wen),
    .rf_x_address(rf_x_address), .rf_y_address(rf_y_address),
    .rf_x_data(rf_x_data), .rf_y_data(rf_y_data),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .kill(kill),
    .of_valid(of_valid), .of_ready(of_ready), .of_opa(of_opa), .of_opb(of_opb),
    .of_dest(of_dest), .of_wen(of_wen), .sb_underflow(sb_underflow)
  );

  // Stimulus helpers
  task automatic idle();
    id_valid = 0; id_x_addr = 0; id_y_addr = 0; id_use_x = 0; id_use_y = 0;
    id_kk = 0; id_wen = 0; ex_fwd_valid = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    wb_valid = 0; wb_addr = 0; kill = 0; of_ready = 1;
  endtask

  task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic ux,
                       input logic uy, input logic w, input logic [7:0] kk);
    id_valid = 1; id_x_addr = x; id_y_addr = y; id_use_x = ux; id_use_y = uy;
    id_wen = w; id_kk = kk;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 17);
    @(posedge clk); #1;
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    #1;
    n_checks++;
    if ({of_valid, of_opa, of_opb, of_dest, of_wen, sb_underflow} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h d=%h w=%b uf=%b, want all zero",
               of_valid, of_opa, of_opb, of_dest, of_wen, sb_underflow);
    end
    tick();
    reset = 1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_id_ready: got %b want 1", id_ready);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    rf_mem[3] = 8'h55; rf_mem[4] = 8'hAA;
    issue(4'd3, 4'd4, 1, 1, 1, 8'h00);
    #1;
    n_checks++;
    if ({id_ready, rf_x_address, rf_y_address} !== {1'b1, 4'd3, 4'd4}) begin
      n_fail++; $display("FAIL nohaz_ready_addr: got r=%b x=%h y=%h want r=1 x=3 y=4",
                         id_ready, rf_x_address, rf_y_address);
    end
    tick();
    idle();
    n_checks++;
    if ({of_valid, of_opa, of_opb, of_dest, of_wen} !== {1'b1, 8'h55, 8'hAA, 4'd3, 1'b1}) begin
      n_fail++; $display("FAIL nohaz_out: got v=%b a=%h b=%h d=%h w=%b want 1 55 AA 3 1",
                         of_valid, of_opa, of_opb, of_dest, of_wen);
    end
    tick();
    // pend[3] is still 1: a reader of s3 stalls until a release arrives.
    issue(4'd3, 4'd0, 1, 0, 0, 8'h7E);
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++; $display("FAIL nohaz_pend3_stall: got id_ready=%b want 0", id_ready);
    end
    wb_valid = 1; wb_addr = 4'd3;
    tick();
    wb_valid = 0;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL nohaz_pend3_release: got id_ready=%b want 1", id_ready);
    end
    tick();
    n_checks++;
    if ({of_valid, of_opa, of_opb} !== {1'b1, 8'h55, 8'h7E}) begin
      n_fail++; $display("FAIL nohaz_kk: got v=%b a=%h b=%h want 1 55 7E", of_valid, of_opa, of_opb);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rf_mem[5] = 8'h21; rf_mem[2] = 8'h77;
    issue(4'd2, 4'd0, 0, 0, 1, 8'h10);
    tick();
    issue(4'd5, 4'd2, 1, 1, 1, 8'h00);
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_bubble: got id_ready=%b want 0", id_ready);
    end
    tick();
    ex_fwd_valid = 1; ex_fwd_addr = 4'd2; ex_fwd_data = 8'h10;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_forward_ready: got id_ready=%b want 1", id_ready);
    end
    tick();
    idle();
    n_checks++;
    if ({of_valid, of_opa, of_opb, of_dest} !== {1'b1, 8'h21, 8'h10, 4'd5}) begin
      n_fail++; $display("FAIL b2b_out: got v=%b a=%h b=%h d=%h want 1 21 10 5",
                         of_valid, of_opa, of_opb, of_dest);
    end
  endtask

  task automatic test_pending();
    do_reset();
    issue(4'd7, 4'd0, 0, 0, 1, 8'h00);
    tick();
    idle();
    tick();
    rf_mem[7] = 8'h99;
    issue(4'd7, 4'd0, 1, 0, 0, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin
        n_fail++; $display("FAIL pend_stall_%0d: got id_ready=%b want 0", i, id_ready);
      end
      tick();
    end
    wb_valid = 1; wb_addr = 4'd7;
    tick();
    wb_valid = 0;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL pend_release: got id_ready=%b want 1", id_ready);
    end
    tick();
    idle();
    n_checks++;
    if ({of_valid, of_opa, of_opb, of_wen} !== {1'b1, 8'h99, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL pend_out: got v=%b a=%h b=%h w=%b want 1 99 3C 0",
                         of_valid, of_opa, of_opb, of_wen);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rf_mem[1] = 8'h11; rf_mem[6] = 8'h66;
    issue(4'd1, 4'd0, 1, 0, 0, 8'h22);
    tick();
    of_ready = 0;
    issue(4'd6, 4'd0, 1, 0, 0, 8'h44);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready_%0d: got %b want 0", i, id_ready);
      end
      tick();
      n_checks++;
      if ({of_valid, of_opa, of_opb} !== {1'b1, 8'h11, 8'h22}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got v=%b a=%h b=%h want 1 11 22",
                           i, of_valid, of_opa, of_opb);
      end
    end
    of_ready = 1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_resume_ready: got %b want 1", id_ready);
    end
    tick();
    idle();
    n_checks++;
    if ({of_valid, of_opa, of_opb} !== {1'b1, 8'h66, 8'h44}) begin
      n_fail++; $display("FAIL bp_next: got v=%b a=%h b=%h want 1 66 44", of_valid, of_opa, of_opb);
    end
  endtask

  task automatic test_kill();
    do_reset();
    issue(4'd9, 4'd0, 0, 0, 1, 8'h00);
    tick();
    issue(4'd1, 4'd0, 0, 0, 0, 8'h00);
    of_ready = 0; kill = 1; wb_valid = 1; wb_addr = 4'd9;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++; $display("FAIL kill_blocks_accept: got id_ready=%b want 0", id_ready);
    end
    tick();
    idle();
    n_checks++;
    if ({of_valid, sb_underflow} !== 2'b01) begin
      n_fail++; $display("FAIL kill_out: got v=%b uf=%b want v=0 uf=1", of_valid, sb_underflow);
    end
    issue(4'd9, 4'd0, 1, 0, 0, 8'h00);
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_pend9_clear: got id_ready=%b want 1", id_ready);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_valid = 1; wb_addr = 4'd0;
    tick();
    issue(4'd4, 4'd0, 0, 0, 1, 8'h5A);
    wb_valid = 0;
    tick();
    idle();
    of_ready = 0;
    n_checks++;
    if ({of_valid, sb_underflow} !== 2'b11) begin
      n_fail++; $display("FAIL rmid_setup: got v=%b uf=%b want 1 1", of_valid, sb_underflow);
    end
    #2;
    reset = 0;
    #1;
    n_checks++;
    if ({of_valid, of_opb, of_dest, of_wen, sb_underflow} !== 15'd0) begin
      n_fail++; $display("FAIL rmid_async: got v=%b b=%h d=%h w=%b uf=%b want all zero",
                         of_valid, of_opb, of_dest, of_wen, sb_underflow);
    end
    tick();
    reset = 1;
    of_ready = 1;
    issue(4'd4, 4'd0, 1, 0, 1, 8'h00);
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_counters_clear: got id_ready=%b want 1", id_ready);
    end
    tick();
    idle();
  endtask

  // Behavioural model state for the randomized run
  int         m_pend [16];
  bit         m_uf, m_valid, m_wen, m_use_x;
  logic [7:0] m_opa, m_opb;
  logic [3:0] m_dest;

  function automatic bit m_blocks(input logic [3:0] r);
    if (m_valid && m_wen && m_dest == r) return 1;
    if (ex_fwd_valid && ex_fwd_addr == r) return 0;
    return m_pend[r] != 0;
  endfunction

  function automatic logic [7:0] m_value(input logic [3:0] r);
    return (ex_fwd_valid && ex_fwd_addr == r) ? ex_fwd_data : rf_mem[r];
  endfunction

  task automatic test_random();
    bit exp_ready, acc;
    int p;
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
    m_uf = 0; m_valid = 0; m_wen = 0; m_use_x = 0; m_opa = 0; m_opb = 0; m_dest = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 16; i++) rf_mem[i] = 8'($urandom);
      id_valid  = ($urandom % 4) != 0;
      id_x_addr = 4'($urandom_range(0, 5));
      id_y_addr = 4'($urandom_range(0, 5));
      id_use_x  = 1'($urandom);
      id_use_y  = 1'($urandom);
      id_wen    = 1'($urandom);
      id_kk     = 8'($urandom);
      of_ready  = ($urandom % 4) != 0;
      kill      = ($urandom % 16) == 0;
      ex_fwd_valid = ($urandom % 3) == 0;
      ex_fwd_addr  = 4'($urandom_range(0, 5));
      ex_fwd_data  = 8'($urandom);
      r = 4'($urandom_range(0, 5));
      wb_addr  = r;
      wb_valid = (m_pend[r] > 0) ? (($urandom % 3) == 0) : (($urandom % 64) == 0);
      #1;
      exp_ready = !((id_use_x && m_blocks(id_x_addr)) || (id_use_y && m_blocks(id_y_addr)) ||
                    (id_wen && m_pend[id_x_addr] == 3)) && !kill && (!m_valid || of_ready);
      n_checks++;
      if (id_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, id_ready, exp_ready);
      end
      acc = id_valid && exp_ready;
      for (int k = 0; k < 16; k++) begin
        p = m_pend[k];
        if (acc && id_wen && id_x_addr == 4'(k)) p++;
        if (wb_valid && wb_addr == 4'(k)) p--;
        if (kill && m_valid && m_wen && m_dest == 4'(k)) p--;
        if (p < 0) begin m_uf = 1; p = 0; end
        if (p > 3) p = 3;
        m_pend[k] = p;
      end
      if (acc) begin
        m_valid = 1; m_wen = id_wen; m_dest = id_x_addr; m_use_x = id_use_x;
        m_opa = m_value(id_x_addr);
        m_opb = id_use_y ? m_value(id_y_addr) : id_kk;
      end else if (of_ready || kill) begin
        m_valid = 0;
      end
      tick();
      n_checks++;
      if ({of_valid, sb_underflow} !== {m_valid, m_uf}) begin
        n_fail++; $display("FAIL rand_state cyc %0d: got v=%b uf=%b want v=%b uf=%b",
                           cyc, of_valid, sb_underflow, m_valid, m_uf);
      end
      if (m_valid) begin
        n_checks++;
        if ({of_opb, of_dest, of_wen} !== {m_opb, m_dest, m_wen} ||
            (m_use_x && of_opa !== m_opa)) begin
          n_fail++; $display("FAIL rand_out cyc %0d: got a=%h b=%h d=%h w=%b want a=%h b=%h d=%h w=%b",
                             cyc, of_opa, of_opb, of_dest, of_wen, m_opa, m_opb, m_dest, m_wen);
        end
      end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
    #2;
    test_reset();
    test_no_hazard();
    test_back_to_back();
    test_pending();
    test_backpressure();
    test_kill();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kcpsmx_operand_fetch.md
Name: kcpsmx_operand_fetch

Overview:
- Operand-fetch stage of the pipelined KCPSMX core, between decode and execute.
- Drives the x/y read ports of the 16-entry register file and applies EX-stage forwarding.
- Keeps a per-register scoreboard of in-flight writes to detect RAW hazards and stall decode.
- Registers the selected operands into a valid/ready output stage feeding execute.

Parameters:
- REGISTER_DEPTH, 4, register address width (from shared package)
- REGISTER_WIDTH, 8, data width (from shared package)
- REGISTER_SIZE, 16, number of registers (from shared package)
- PEND_W, 2, width of per-register in-flight write counter

Ports:
- clk  input  1  core clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- id_valid  input  1  decode presents an instruction
- id_ready  output  1  fetch accepts the instruction this cycle
- id_x_addr  input  REGISTER_DEPTH  sX field; also the destination register
- id_y_addr  input  REGISTER_DEPTH  sY field
- id_use_x  input  1  instruction reads sX
- id_use_y  input  1  instruction reads sY (0 means operand B = kk)
- id_kk  input  REGISTER_WIDTH  immediate constant
- id_wen  input  1  instruction writes sX
- rf_x_address  output  REGISTER_DEPTH  register-file x read address (= id_x_addr)
- rf_y_address  output  REGISTER_DEPTH  register-file y read address (= id_y_addr)
- rf_x_data  input  REGISTER_WIDTH  register-file x read data
- rf_y_data  input  REGISTER_WIDTH  register-file y read data
- ex_fwd_valid  input  1  execute result valid this cycle
- ex_fwd_addr  input  REGISTER_DEPTH  execute result destination
- ex_fwd_data  input  REGISTER_WIDTH  execute result value
- wb_valid  input  1  an issued writing instruction retires or is killed; releases one scoreboard count
- wb_addr  input  REGISTER_DEPTH  destination being released
- kill  input  1  invalidate the output-stage entry (branch flush)
- of_valid  output  1  output stage holds an instruction
- of_ready  input  1  execute accepts output stage
- of_opa  output  REGISTER_WIDTH  operand A
- of_opb  output  REGISTER_WIDTH  operand B
- of_dest  output  REGISTER_DEPTH  destination register
- of_wen  output  1  destination write enable
- sb_underflow  output  1  sticky error: release arrived for a register with zero count

Behaviour:
- Reset (async, active-low):
  - of_valid=0, of_opa=of_opb=0, of_dest=0, of_wen=0.
  - All scoreboard counters 0; sb_underflow=0.
- Read addresses are combinational pass-through of the id fields. Register-file data is used in the same cycle; the register file writes on negedge, so a same-cycle writeback is already visible.
- Hazard for a used operand register r, in priority order:
  1. of_valid && of_wen && of_dest==r: stall. This is a 1-bubble dependency on the instruction just ahead.
  2. ex_fwd_valid && ex_fwd_addr==r: forward ex_fwd_data.
  3. pend[r]!=0: stall.
  4. Otherwise use register-file data.
- Unused operands never cause a stall.
- id_ready = !stall && (!of_valid || of_ready).
- Accept = id_valid && id_ready.
  - On accept: load the output stage, with opb = id_use_y ? y operand : id_kk; of_valid=1.
  - Else if of_ready: of_valid=0.
  - Else hold all outputs stable.
- Scoreboard counters:
  - Increment pend[id_x_addr] on accept with id_wen.
  - Decrement pend[wb_addr] on wb_valid.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - Counter saturates at max; at max, a new writer of that register stalls in decode.
  - wb_valid on a zero counter: counter stays 0, sb_underflow set (sticky until reset).
- kill:
  - Forces of_valid=0 next cycle and blocks accept this cycle (id_ready=0).
  - If the killed entry had of_wen, pend[of_dest] decrements, combined with any wb_valid arithmetic (two releases on one register subtract 2, floor 0).
  - Downstream killed instructions still pulse wb_valid to release their counts.
- Reset mid-stall: reset alone clears all state; no partial release.

Decomposition:
- In kcpsmx3_inc:
  - REGISTER_DEPTH, REGISTER_WIDTH, REGISTER_SIZE.
  - New typedefs reg_addr_t, reg_data_t, and a PEND_W pend_cnt_t.
- One sub-module, kcpsmx_scoreboard:
  - Holds the 16 counters plus the inc/dec/kill arithmetic and the underflow flag.
  - Exposes a busy vector.
- Hazard/forward mux and the output register stay in the top.

Test Plan:
- No hazard: rf r3=0x55, r4=0xAA; issue ADD s3,s4 (use_x, use_y, wen) -> next cycle of_valid=1, opa=0x55, opb=0xAA, dest=3, pend[3]=1.
- Back-to-back RAW: issue LOAD s2,0x10 (wen), then ADD s5,s2 with of_ready=1 -> 1 cycle id_ready=0, then accepted with opb=ex_fwd_data 0x10 (ex_fwd_valid, addr=2).
- Pending without forward: pend[7]=1, no EX match; issue reads s7 -> id_ready=0 until wb_valid addr=7, then accepted with rf_x_data.
- Backpressure: of_valid=1, of_ready=0 for 3 cycles -> outputs unchanged, id_ready=0; of_ready=1 -> next instruction loads.
- Kill: output holds writer dest=9 (pend[9]=1), assert kill with wb_valid addr=9 -> of_valid=0, pend[9]=0, sb_underflow=1.
- Reset mid-operation: assert reset low asynchronously with of_valid=1, pend nonzero -> immediately of_valid=0, all counters 0, sb_underflow=0.
